// File: rtl/mips_bus_lsu_if.sv
// Bundle between the MIPS core, the load/store unit and the Avalon-MM bus.
// The master modport is the LSU view; the slave modport is the core/memory side.
interface mips_bus_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_op;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_rt_old;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;

    modport master (
        input  req_valid, req_write, req_op, req_signed, req_addr, req_wdata, req_rt_old,
        input  waitrequest, readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output address, read, write, byteenable, writedata
    );

    modport slave (
        output req_valid, req_write, req_op, req_signed, req_addr, req_wdata, req_rt_old,
        output waitrequest, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  address, read, write, byteenable, writedata
    );
endinterface

// File: rtl/mips_bus_lsu.sv
// Load/store unit: one core request at a time onto Avalon-MM, with byte lanes,
// sub-word extension, LWL/LWR merge, selectable endianness and timeout abort.
module mips_bus_lsu #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 255
) (
    input logic            clk,
    input logic            reset,
    mips_bus_lsu_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_DONE = 2'd2} state_e;

    localparam logic [2:0] OP_BYTE  = 3'd0;
    localparam logic [2:0] OP_HALF  = 3'd1;
    localparam logic [2:0] OP_WORD  = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_RIGHT = 3'd4;
    // Counter only needs to reach TIMEOUT-1: the abort fires on the edge that would make it TIMEOUT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              read_q, read_d, write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [2:0]        op_q, op_d;
    logic              signed_q, signed_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rt_old_q, rt_old_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic is_illegal(input logic wr, input logic [2:0] op, input logic [1:0] b);
        logic bad;
        case (op)
            OP_BYTE:           bad = 1'b0;
            OP_HALF:           bad = b[0];
            OP_WORD:           bad = (b != 2'b00);
            OP_LEFT, OP_RIGHT: bad = wr;
            default:           bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [2:0] op, input logic [1:0] b);
        logic [3:0] m;
        case (op)
            OP_BYTE: m = 4'b0001 << b;
            OP_HALF: m = 4'b0011 << b;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Half stores are naturally aligned, so the lane pair is simply replicated.
    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] d;
        case (op)
            OP_BYTE: d = {4{wd[7:0]}};
            OP_HALF: d = BIG_ENDIAN ? {2{wd[7:0], wd[15:8]}} : {2{wd[15:0]}};
            default: d = BIG_ENDIAN ? bswap(wd) : wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0] op, input logic sgn, input logic [1:0] b,
                                              input logic [31:0] rd, input logic [31:0] rt);
        logic [31:0] w, r;
        logic [7:0]  byte_v;
        logic [15:0] half_raw, half_v;
        logic [1:0]  bp, bq;
        logic [4:0]  sh_l, sh_r;
        w        = BIG_ENDIAN ? bswap(rd) : rd;
        byte_v   = 8'(rd >> {b, 3'b000});
        half_raw = 16'(rd >> {b, 3'b000});
        half_v   = BIG_ENDIAN ? {half_raw[7:0], half_raw[15:8]} : half_raw;
        bp       = BIG_ENDIAN ? b : (2'd3 - b);
        bq       = 2'd3 - bp;
        sh_l     = {bp, 3'b000};
        sh_r     = {bq, 3'b000};
        case (op)
            OP_BYTE:  r = {{24{sgn & byte_v[7]}}, byte_v};
            OP_HALF:  r = {{16{sgn & half_v[15]}}, half_v};
            OP_WORD:  r = w;
            OP_LEFT:  r = (w << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
            OP_RIGHT: r = (w >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
            default:  r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = 32'h0000_0000;
        op_d         = op_q;
        signed_d     = signed_q;
        off_d        = off_q;
        rt_old_d     = rt_old_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    signed_d = bus.req_signed;
                    off_d    = bus.req_addr[1:0];
                    rt_old_d = bus.req_rt_old;
                    if (is_illegal(bus.req_write, bus.req_op, bus.req_addr[1:0])) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        read_d  = ~bus.req_write;
                        write_d = bus.req_write;
                        addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        be_d    = lane_enable(bus.req_op, bus.req_addr[1:0]);
                        wdata_d = bus.req_write ? store_data(bus.req_op, bus.req_wdata) : 32'h0000_0000;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (!bus.waitrequest) begin
                    state_d      = ST_DONE;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    rdata_d      = read_q ? load_data(op_q, signed_q, off_q, bus.readdata, rt_old_q)
                                          : 32'h0000_0000;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d      = ST_DONE;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            op_q         <= 3'd0;
            signed_q     <= 1'b0;
            off_q        <= 2'd0;
            rt_old_q     <= 32'h0000_0000;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
            op_q         <= op_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            rt_old_q     <= rt_old_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.address    = addr_q;
    assign bus.byteenable = be_q;
    assign bus.writedata  = wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_mips_bus_lsu.sv
// Drives a big-endian and a little-endian LSU with identical requests and
// compares both against a byte-lane reference model.
module tb_mips_bus_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_write, req_signed, waitrequest;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_rt_old, readdata;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] last_rd_be, last_wd_be;
    logic        last_err_be;

    always #5 clk = ~clk;

    mips_bus_lsu_if #(.ADDR_W(32)) ifb ();
    mips_bus_lsu_if #(.ADDR_W(32)) ifl ();

    assign ifb.req_valid = req_valid;   assign ifl.req_valid = req_valid;
    assign ifb.req_write = req_write;   assign ifl.req_write = req_write;
    assign ifb.req_op = req_op;         assign ifl.req_op = req_op;
    assign ifb.req_signed = req_signed; assign ifl.req_signed = req_signed;
    assign ifb.req_addr = req_addr;     assign ifl.req_addr = req_addr;
    assign ifb.req_wdata = req_wdata;   assign ifl.req_wdata = req_wdata;
    assign ifb.req_rt_old = req_rt_old; assign ifl.req_rt_old = req_rt_old;
    assign ifb.waitrequest = waitrequest; assign ifl.waitrequest = waitrequest;
    assign ifb.readdata = readdata;     assign ifl.readdata = readdata;

    mips_bus_lsu #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(TO)) dut_be (.clk(clk), .reset(reset), .bus(ifb));
    mips_bus_lsu #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(TO)) dut_le (.clk(clk), .reset(reset), .bus(ifl));

    // Index 0 = big-endian instance, 1 = little-endian instance.
    logic [1:0]  o_ready, o_read, o_write, o_rv, o_err;
    logic [31:0] o_addr[2], o_wd[2], o_rd[2];
    logic [3:0]  o_be[2];
    assign o_ready = {ifl.req_ready, ifb.req_ready};
    assign o_read  = {ifl.read, ifb.read};
    assign o_write = {ifl.write, ifb.write};
    assign o_rv    = {ifl.resp_valid, ifb.resp_valid};
    assign o_err   = {ifl.resp_err, ifb.resp_err};
    assign o_addr[0] = ifb.address;    assign o_addr[1] = ifl.address;
    assign o_wd[0] = ifb.writedata;    assign o_wd[1] = ifl.writedata;
    assign o_rd[0] = ifb.resp_rdata;   assign o_rd[1] = ifl.resp_rdata;
    assign o_be[0] = ifb.byteenable;   assign o_be[1] = ifl.byteenable;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input int d, input string name);
        return $sformatf("%s.%s", (d == 0) ? "be" : "le", name);
    endfunction

    // ---- reference model: byte lanes as arrays ----
    function automatic bit ref_illegal(input logic wr, input logic [2:0] op, input logic [31:0] a);
        return (op > 3'd4) || (wr && op >= 3'd3) || (op == 3'd1 && a[0]) || (op == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] m;
        int b;
        b = int'(a[1:0]);
        m = 4'b0000;
        if (op == 3'd0) m[b] = 1'b1;
        else if (op == 3'd1) begin m[b] = 1'b1; m[b+1] = 1'b1; end
        else m = 4'b1111;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input bit be, input logic [2:0] op, input logic [31:0] wd);
        logic [7:0] l[4];
        for (int i = 0; i < 4; i++) begin
            if (op == 3'd0) l[i] = wd[7:0];
            else if (op == 3'd1) l[i] = ((i % 2 == 0) == be) ? wd[15:8] : wd[7:0];
            else l[i] = be ? wd[8*(3-i) +: 8] : wd[8*i +: 8];
        end
        return {l[3], l[2], l[1], l[0]};
    endfunction

    function automatic logic [31:0] ref_load(input bit be, input logic [2:0] op, input logic sg,
                                             input logic [31:0] a, input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0]  l[4];
        logic [31:0] w;
        logic [15:0] h;
        int b, bp;
        for (int i = 0; i < 4; i++) l[i] = rd[8*i +: 8];
        b  = int'(a[1:0]);
        w  = be ? {l[0], l[1], l[2], l[3]} : {l[3], l[2], l[1], l[0]};
        bp = be ? b : 3 - b;
        case (op)
            3'd0: return (sg && l[b][7]) ? {24'hFFFFFF, l[b]} : {24'h0, l[b]};
            3'd1: begin
                h = be ? {l[b], l[b+1]} : {l[b+1], l[b]};
                return (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
            end
            3'd2: return w;
            3'd3: return (w << (8*bp)) | (rt & ~(32'hFFFFFFFF << (8*bp)));
            3'd4: return (w >> (8*(3-bp))) | (rt & ~(32'hFFFFFFFF >> (8*(3-bp))));
            default: return 32'h0;
        endcase
    endfunction

    // One request from idle through the response pulse; nwait = waitrequest-high cycles.
    task automatic do_txn(input logic wr, input logic [2:0] op, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] rd, input int nwait);
        bit bad, tmo, err;
        int held;
        logic [31:0] exp_rd;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_eq(tg(d, "req_ready_idle"), 32'(o_ready[d]), 32'd1);
        req_valid = 1'b1; req_write = wr; req_op = op; req_signed = sg;
        req_addr = a; req_wdata = wd; req_rt_old = rt;
        waitrequest = 1'b1; readdata = $urandom;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_op = 3'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rt_old = $urandom;
        bad = ref_illegal(wr, op, a);
        tmo = !bad && (nwait >= TO);
        err = bad || tmo;
        if (!bad) begin
            held = tmo ? TO : nwait + 1;
            for (int k = 0; k < held; k++) begin
                waitrequest = (k < nwait);
                readdata = (k < nwait) ? $urandom : rd;
                for (int d = 0; d < 2; d++) begin
                    check_eq(tg(d, "read"), 32'(o_read[d]), 32'(!wr));
                    check_eq(tg(d, "write"), 32'(o_write[d]), 32'(wr));
                    check_eq(tg(d, "address"), o_addr[d], {a[31:2], 2'b00});
                    check_eq(tg(d, "byteenable"), 32'(o_be[d]), 32'(ref_be(op, a)));
                    check_eq(tg(d, "busy_ready"), 32'(o_ready[d]), 32'd0);
                    check_eq(tg(d, "early_resp"), 32'(o_rv[d]), 32'd0);
                    if (wr) check_eq(tg(d, "writedata"), o_wd[d], ref_wdata(d == 0, op, wd));
                end
                last_wd_be = o_wd[0];
                @(negedge clk);
            end
        end
        waitrequest = 1'($urandom); readdata = $urandom;
        for (int d = 0; d < 2; d++) begin
            exp_rd = (err || wr) ? 32'h0 : ref_load(d == 0, op, sg, a, rd, rt);
            check_eq(tg(d, "resp_valid"), 32'(o_rv[d]), 32'd1);
            check_eq(tg(d, "resp_err"), 32'(o_err[d]), 32'(err));
            check_eq(tg(d, "resp_rdata"), o_rd[d], exp_rd);
            check_eq(tg(d, "done_read"), 32'(o_read[d] | o_write[d]), 32'd0);
            check_eq(tg(d, "done_ready"), 32'(o_ready[d]), 32'd0);
        end
        last_rd_be = o_rd[0];
        last_err_be = o_err[0];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq(tg(d, "resp_pulse"), 32'(o_rv[d]), 32'd0);
            check_eq(tg(d, "ready_again"), 32'(o_ready[d]), 32'd1);
        end
        waitrequest = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        for (int d = 0; d < 2; d++) begin
            check_eq(tg(d, {name, ".req_ready"}), 32'(o_ready[d]), 32'd1);
            check_eq(tg(d, {name, ".rd_wr"}), 32'({o_read[d], o_write[d]}), 32'd0);
            check_eq(tg(d, {name, ".resp"}), 32'({o_rv[d], o_err[d]}), 32'd0);
            check_eq(tg(d, {name, ".address"}), o_addr[d], 32'd0);
            check_eq(tg(d, {name, ".byteenable"}), 32'(o_be[d]), 32'd0);
            check_eq(tg(d, {name, ".writedata"}), o_wd[d], 32'd0);
            check_eq(tg(d, {name, ".resp_rdata"}), o_rd[d], 32'd0);
        end
    endtask

    initial begin
        logic       wr, sg;
        logic [2:0] op;
        int         nw;
        req_valid = 1'b0; req_write = 1'b0; req_op = 3'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rt_old = 32'd0;
        waitrequest = 1'b0; readdata = 32'd0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        do_txn(1'b0, 3'd2, 1'b0, 32'h100, 32'h0, 32'h0, 32'h78563412, 0);
        check_eq("t1_lw_rdata", last_rd_be, 32'h12345678);
        do_txn(1'b0, 3'd0, 1'b1, 32'h103, 32'h0, 32'h0, 32'h80000000, 0);
        check_eq("t2_lb_signed", last_rd_be, 32'hFFFFFF80);
        do_txn(1'b0, 3'd0, 1'b0, 32'h103, 32'h0, 32'h0, 32'h80000000, 0);
        check_eq("t2_lbu", last_rd_be, 32'h00000080);
        do_txn(1'b1, 3'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 32'h0, 3);
        check_eq("t3_sh_writedata", last_wd_be, 32'hCDABCDAB);
        do_txn(1'b0, 3'd1, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0, 0);
        check_eq("t4_misaligned_err", 32'(last_err_be), 32'd1);
        do_txn(1'b0, 3'd2, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 9);
        check_eq("t5_timeout_err", 32'(last_err_be), 32'd1);

        // Reset in the middle of a stalled read.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_op = 3'd2; req_addr = 32'h200; waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int d = 0; d < 2; d++) check_eq(tg(d, "pre_reset_read"), 32'(o_read[d]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_eq(tg(d, "no_resp_after_reset"), 32'(o_rv[d]), 32'd0);
        reset = 1'b1;
        waitrequest = 1'b0;
        @(negedge clk);
        check_reset_state("post_reset");

        do_txn(1'b0, 3'd3, 1'b0, 32'h101, 32'h0, 32'hAABBCCDD, 32'h44332211, 0);
        check_eq("t6_lwl", last_rd_be, 32'h223344DD);
        do_txn(1'b0, 3'd4, 1'b0, 32'h101, 32'h0, 32'hAABBCCDD, 32'h44332211, 0);
        check_eq("t6_lwr", last_rd_be, 32'hAABB1122);
        do_txn(1'b1, 3'd3, 1'b0, 32'h100, 32'h1, 32'h0, 32'h0, 0);
        check_eq("store_left_illegal", 32'(last_err_be), 32'd1);
        do_txn(1'b0, 3'd6, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0);
        check_eq("op6_illegal", 32'(last_err_be), 32'd1);

        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            wr = 1'($urandom);
            sg = 1'($urandom);
            nw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            do_txn(wr, op, sg, $urandom, $urandom, $urandom, $urandom, nw);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
